// File: rtl/output_display_if.sv
// Result-bus interface for the output display: capture request and data in,
// busy and the multiplexed 7-segment drive out.
interface output_display_if;
  logic       load;
  logic [7:0] data;
  logic       signed_mode;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] digit_en;

  // Producer side: issues values to show and watches the display outputs.
  modport master (
    output load, data, signed_mode,
    input  busy, seg, digit_en
  );

  // Display block side.
  modport slave (
    input  load, data, signed_mode,
    output busy, seg, digit_en
  );
endinterface

// File: rtl/output_display.sv
// Output display: captures an 8-bit (unsigned or two's complement) result,
// converts its magnitude to three BCD digits with a bit-serial double-dabble
// engine, and scans a 4-digit 7-segment display (sign, hundreds, tens, ones).
module output_display #(
  parameter int CLK_DIV = 1024
) (
  input  logic             clk,
  input  logic             reset,
  output_display_if.slave  bus
);

  localparam int PW = $clog2(CLK_DIV);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  mag_q, mag_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  step_q, step_d;
  logic        conv_neg_q, conv_neg_d;

  logic [3:0]  hund_q, hund_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        neg_q, neg_d;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    digit_en_q, digit_en_d;

  logic [11:0] bcd_adj;
  logic [19:0] shifted;
  logic        presc_wrap;

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
  for (genvar gi = 0; gi < 3; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
  end

  // The bcd top bit drops out harmlessly: 255 needs at most 10 BCD bits.
  assign shifted = {bcd_adj[10:0], mag_q, 1'b0};

  assign presc_wrap = (presc_q == PW'(CLK_DIV - 1));

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0: p = 7'h3F;
      4'd1: p = 7'h06;
      4'd2: p = 7'h5B;
      4'd3: p = 7'h4F;
      4'd4: p = 7'h66;
      4'd5: p = 7'h6D;
      4'd6: p = 7'h7D;
      4'd7: p = 7'h07;
      4'd8: p = 7'h7F;
      4'd9: p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // Conversion FSM: capture in IDLE, eight shift steps in CONVERT, then
  // commit all display registers together on the last step.
  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    step_d     = step_q;
    conv_neg_d = conv_neg_q;
    hund_d     = hund_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    neg_d      = neg_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          conv_neg_d = bus.signed_mode & bus.data[7];
          mag_d      = (bus.signed_mode & bus.data[7]) ? (~bus.data + 8'd1) : bus.data;
          bcd_d      = '0;
          step_d     = '0;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d  = shifted[19:8];
        mag_d  = shifted[7:0];
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          hund_d  = shifted[19:16];
          tens_d  = shifted[15:12];
          ones_d  = shifted[11:8];
          neg_d   = conv_neg_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan prescaler and segment selection; uses next-state display values so a
  // commit and a digit advance on the same edge show the new value at once.
  always_comb begin
    presc_d = presc_wrap ? '0 : presc_q + PW'(1);
    idx_d   = presc_wrap ? idx_q + 2'd1 : idx_q;
    seg_d   = 7'h00;
    case (idx_d)
      2'd0: seg_d = seg_pat(ones_d);
      2'd1: seg_d = ((hund_d == 4'd0) && (tens_d == 4'd0)) ? 7'h00 : seg_pat(tens_d);
      2'd2: seg_d = (hund_d == 4'd0) ? 7'h00 : seg_pat(hund_d);
      2'd3: seg_d = neg_d ? 7'h40 : 7'h00;
      default: seg_d = 7'h00;
    endcase
    digit_en_d = 4'b0001 << idx_d;
  end

  // State register; reset also clears the display so an aborted load shows "0".
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      bcd_q      <= '0;
      step_q     <= '0;
      conv_neg_q <= 1'b0;
      hund_q     <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      neg_q      <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      seg_q      <= 7'h3F;
      digit_en_q <= 4'b0001;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      step_q     <= step_d;
      conv_neg_q <= conv_neg_d;
      hund_q     <= hund_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      neg_q      <= neg_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      digit_en_q <= digit_en_d;
    end
  end

  assign bus.busy     = (state_q == CONVERT);
  assign bus.seg      = seg_q;
  assign bus.digit_en = digit_en_q;

endmodule
